// File: rtl/rat_loader_pkg.sv
// Shared types and constants for the RAT MCU serial program loader.
package rat_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_CSUM
  } loader_state_t;

  localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_HDR_BYTES = 3;
  localparam int         BYTES_PER_WORD  = 3;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: reloads on every restart, counts down while active,
// and flags expiry on the TIMEOUT_CYC-th consecutive quiet clock.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic active,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = CW'(TIMEOUT_CYC);
    end else if (!active) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = active && !restart && (cnt_q == CW'(1));

endmodule

// File: rtl/prog_loader.sv
// Serial bootloader for the RAT program memory: unpacks a framed UART byte
// stream into 18-bit words and arbitrates the memory port against the CPU.
module prog_loader
  import rat_loader_pkg::*;
#(
  parameter int         ADDR_W      = 10,
  parameter int         DATA_W      = 18,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  output logic              CPU_HOLD,
  output logic              CPU_RST,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR
);

  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

  loader_state_t     state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        b0_q, b0_d;
  logic [7:0]        b1_q, b1_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] la_q, la_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic [ADDR_W:0]   words_inc;
  logic [15:0]       n_rx;
  logic              tmo_expire;

  loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (CLK),
    .rst    (RST),
    .restart(RX_VALID),
    .active (state_q != ST_IDLE),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    chk_d       = chk_q;
    words_d     = words_q;
    la_d        = la_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    cpu_hold_d  = cpu_hold_q;
    cpu_rst_d   = 1'b0;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    words_inc   = words_q + (ADDR_W + 1)'(1);
    n_rx        = {n_q[15:8], RX_DATA};

    if (RX_VALID) begin
      case (state_q)
        ST_IDLE: begin
          if (RX_DATA == SYNC_BYTE) begin
            state_d    = ST_CNT_HI;
            cpu_hold_d = 1'b1;
            load_err_d = 1'b0;
          end
        end
        ST_CNT_HI: begin
          n_d[15:8] = RX_DATA;
          state_d   = ST_CNT_LO;
        end
        ST_CNT_LO: begin
          n_d = n_rx;
          if (n_rx == 16'd0 || {1'b0, n_rx} > MAX_N) begin
            load_err_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            la_d    = '0;
            words_d = '0;
            chk_d   = '0;
            state_d = ST_W0;
          end
        end
        ST_W0: begin
          // Upper six bits of B0 are reserved; a violation poisons the frame
          // but the stream is still consumed so framing stays aligned.
          chk_d = chk_q ^ RX_DATA;
          b0_d  = RX_DATA[1:0];
          if (RX_DATA[7:2] != 6'd0) begin
            load_err_d = 1'b1;
          end
          state_d = ST_W1;
        end
        ST_W1: begin
          chk_d   = chk_q ^ RX_DATA;
          b1_d    = RX_DATA;
          state_d = ST_W2;
        end
        ST_W2: begin
          chk_d       = chk_q ^ RX_DATA;
          mem_we_d    = 1'b1;
          mem_wdata_d = DATA_W'({b0_q, b1_q, RX_DATA});
          la_d        = words_q[ADDR_W-1:0];
          words_d     = words_inc;
          state_d     = (16'(words_inc) == n_q) ? ST_CSUM : ST_W0;
        end
        ST_CSUM: begin
          if (RX_DATA == chk_q && !load_err_q) begin
            load_done_d = 1'b1;
            cpu_rst_d   = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            load_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (tmo_expire) begin
      state_d    = ST_IDLE;
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      chk_q       <= '0;
      words_q     <= '0;
      la_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      cpu_rst_q   <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      chk_q       <= chk_d;
      words_q     <= words_d;
      la_q        <= la_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      cpu_rst_q   <= cpu_rst_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign MEM_ADDR  = cpu_hold_q ? la_q : CPU_ADDR;
  assign MEM_WE    = mem_we_q;
  assign MEM_WDATA = mem_wdata_q;
  assign CPU_HOLD  = cpu_hold_q;
  assign CPU_RST   = cpu_rst_q;
  assign LOAD_DONE = load_done_q;
  assign LOAD_ERR  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are fed byte by byte and the
// registered outputs are sampled 1ns after the edge that consumed each byte.
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [9:0]  cpu_addr;
  logic [9:0]  mem_addr;
  logic [17:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  int total = 0;
  int bad   = 0;
  int we_count = 0;
  int done_count = 0;

  logic [17:0] mem [1024];

  logic        obs_we, obs_done, obs_rst, obs_hold, obs_err;
  logic [9:0]  obs_addr;
  logic [17:0] obs_wdata;

  prog_loader #(
    .ADDR_W     (10),
    .DATA_W     (18),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(100)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .CPU_ADDR (cpu_addr),
    .MEM_ADDR (mem_addr),
    .MEM_WDATA(mem_wdata),
    .MEM_WE   (mem_we),
    .CPU_HOLD (cpu_hold),
    .CPU_RST  (cpu_rst),
    .LOAD_DONE(load_done),
    .LOAD_ERR (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural program memory plus pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_count <= we_count + 1;
    end
    if (load_done) done_count <= done_count + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at 2ms, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    obs_we    = mem_we;
    obs_addr  = mem_addr;
    obs_wdata = mem_wdata;
    obs_done  = load_done;
    obs_rst   = cpu_rst;
    obs_hold  = cpu_hold;
    obs_err   = load_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%0h exp=0", mem_we); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold got=%0h exp=0", cpu_hold); end
    total++; if ({cpu_rst, load_done, load_err} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%0b exp=000", {cpu_rst, load_done, load_err}); end
    total++; if (mem_addr !== 10'h155) begin bad++; $display("[TB] FAIL reset_addr got=%0h exp=155", mem_addr); end
    total++; if (mem_wdata !== 18'h0) begin bad++; $display("[TB] FAIL reset_wdata got=%0h exp=0", mem_wdata); end
  endtask

  task automatic test_idle_noise();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("[TB] FAIL noise_hold got=%0h exp=0", cpu_hold); end
    total++; if (load_err !== 1'b0) begin bad++; $display("[TB] FAIL noise_err got=%0h exp=0", load_err); end
    total++; if (we_count !== 0) begin bad++; $display("[TB] FAIL noise_we got=%0d exp=0", we_count); end
  endtask

  // Words 0x12345 and 0x0FF00; XOR of the six word bytes is 0x98.
  task automatic test_good_frame();
    int d0 = done_count;
    send_byte(8'hA5);
    total++; if (obs_hold !== 1'b1) begin bad++; $display("[TB] FAIL good_hold_sync got=%0h exp=1", obs_hold); end
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
    total++; if (obs_we !== 1'b1) begin bad++; $display("[TB] FAIL good_we0 got=%0h exp=1", obs_we); end
    total++; if (obs_addr !== 10'h000) begin bad++; $display("[TB] FAIL good_addr0 got=%0h exp=0", obs_addr); end
    total++; if (obs_wdata !== 18'h12345) begin bad++; $display("[TB] FAIL good_data0 got=%0h exp=12345", obs_wdata); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL good_we0_pulse got=%0h exp=0", mem_we); end
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h00);
    total++; if (obs_we !== 1'b1) begin bad++; $display("[TB] FAIL good_we1 got=%0h exp=1", obs_we); end
    total++; if (obs_addr !== 10'h001) begin bad++; $display("[TB] FAIL good_addr1 got=%0h exp=1", obs_addr); end
    total++; if (obs_wdata !== 18'h0FF00) begin bad++; $display("[TB] FAIL good_data1 got=%0h exp=0ff00", obs_wdata); end
    send_byte(8'h98);
    total++; if ({obs_done, obs_rst, obs_hold, obs_err} !== 4'b1100) begin bad++; $display("[TB] FAIL good_finish got=%0b exp=1100", {obs_done, obs_rst, obs_hold, obs_err}); end
    total++; if ({load_done, cpu_rst} !== 2'b00) begin bad++; $display("[TB] FAIL good_pulse_width got=%0b exp=00", {load_done, cpu_rst}); end
    total++; if (mem_addr !== 10'h155) begin bad++; $display("[TB] FAIL good_cpu_addr got=%0h exp=155", mem_addr); end
    total++; if (done_count - d0 !== 1) begin bad++; $display("[TB] FAIL good_done_count got=%0d exp=1", done_count - d0); end
  endtask

  task automatic test_bad_csum();
    int w0 = we_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h00);
    send_byte(8'h00);
    total++; if (we_count - w0 !== 2) begin bad++; $display("[TB] FAIL badcs_writes got=%0d exp=2", we_count - w0); end
    total++; if ({obs_done, obs_rst, obs_hold, obs_err} !== 4'b0011) begin bad++; $display("[TB] FAIL badcs_finish got=%0b exp=0011", {obs_done, obs_rst, obs_hold, obs_err}); end
    total++; if (mem_addr !== 10'h001) begin bad++; $display("[TB] FAIL badcs_held_addr got=%0h exp=1", mem_addr); end
    send_byte(8'hA5);
    total++; if ({obs_hold, obs_err} !== 2'b10) begin bad++; $display("[TB] FAIL recover_sync got=%0b exp=10", {obs_hold, obs_err}); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h00);
    send_byte(8'h98);
    total++; if ({obs_done, obs_hold, obs_err} !== 3'b100) begin bad++; $display("[TB] FAIL recover_finish got=%0b exp=100", {obs_done, obs_hold, obs_err}); end
  endtask

  task automatic test_count_limits();
    int w0 = we_count;
    logic [7:0] cs = 8'h00;
    logic [9:0] idx;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    total++; if ({obs_hold, obs_err} !== 2'b11) begin bad++; $display("[TB] FAIL n0_err got=%0b exp=11", {obs_hold, obs_err}); end
    send_byte(8'hA5);
    total++; if (obs_err !== 1'b0) begin bad++; $display("[TB] FAIL n401_sync_clear got=%0h exp=0", obs_err); end
    send_byte(8'h04); send_byte(8'h01);
    total++; if ({obs_hold, obs_err} !== 2'b11) begin bad++; $display("[TB] FAIL n401_err got=%0b exp=11", {obs_hold, obs_err}); end
    total++; if (we_count !== w0) begin bad++; $display("[TB] FAIL limits_no_we got=%0d exp=%0d", we_count, w0); end
    // Full image: word i = {i[9:8], i[7:0], ~i[7:0]}.
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < 1024; i++) begin
      idx = 10'(i);
      send_byte({6'd0, idx[9:8]});
      send_byte(idx[7:0]);
      send_byte(~idx[7:0]);
      cs = cs ^ {6'd0, idx[9:8]} ^ idx[7:0] ^ ~idx[7:0];
    end
    total++; if ({obs_we, obs_addr} !== {1'b1, 10'h3FF}) begin bad++; $display("[TB] FAIL full_last_addr got=%0h exp=7ff", {obs_we, obs_addr}); end
    total++; if (obs_wdata !== 18'h3FF00) begin bad++; $display("[TB] FAIL full_last_data got=%0h exp=3ff00", obs_wdata); end
    send_byte(cs);
    total++; if ({obs_done, obs_hold, obs_err} !== 3'b100) begin bad++; $display("[TB] FAIL full_finish got=%0b exp=100", {obs_done, obs_hold, obs_err}); end
    total++; if (we_count - w0 !== 1024) begin bad++; $display("[TB] FAIL full_writes got=%0d exp=1024", we_count - w0); end
  endtask

  task automatic test_reserved_bits();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hFD); send_byte(8'h12); send_byte(8'h34);
    total++; if (obs_wdata !== 18'h11234) begin bad++; $display("[TB] FAIL resv_data got=%0h exp=11234", obs_wdata); end
    send_byte(8'hDB);
    total++; if ({obs_done, obs_hold, obs_err} !== 3'b011) begin bad++; $display("[TB] FAIL resv_finish got=%0b exp=011", {obs_done, obs_hold, obs_err}); end
  endtask

  task automatic test_timeout();
    int w0 = we_count;
    bit seen = 1'b0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
    repeat (90) @(posedge clk);
    #1;
    total++; if (load_err !== 1'b0) begin bad++; $display("[TB] FAIL tmo_early got=%0h exp=0", load_err); end
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (load_err === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL tmo_err got=%0h exp=1", seen); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL tmo_hold got=%0h exp=1", cpu_hold); end
    total++; if (we_count !== w0) begin bad++; $display("[TB] FAIL tmo_no_we got=%0d exp=%0d", we_count, w0); end
    // Back in IDLE, a fresh frame starting with SYNC must complete.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
    send_byte(8'h67);
    total++; if ({obs_done, obs_hold, obs_err} !== 3'b100) begin bad++; $display("[TB] FAIL tmo_recover got=%0b exp=100", {obs_done, obs_hold, obs_err}); end
  endtask

  task automatic test_rst_mid_frame();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({mem_we, cpu_hold, cpu_rst, load_done, load_err} !== 5'b00000) begin bad++; $display("[TB] FAIL rst_outputs got=%0b exp=00000", {mem_we, cpu_hold, cpu_rst, load_done, load_err}); end
    total++; if (mem_addr !== 10'h155) begin bad++; $display("[TB] FAIL rst_addr got=%0h exp=155", mem_addr); end
    total++; if (mem[0] !== 18'h10203) begin bad++; $display("[TB] FAIL rst_word0 got=%0h exp=10203", mem[0]); end
    total++; if (mem[1] !== 18'h00506) begin bad++; $display("[TB] FAIL rst_word1 got=%0h exp=00506", mem[1]); end
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    cpu_addr = 10'h155;
    test_reset();
    test_idle_noise();
    test_good_frame();
    test_bad_csum();
    test_count_limits();
    test_reserved_bits();
    test_timeout();
    test_rst_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
